// File: rtl/aes_dec_key_schedule.sv
// AES-128 decryption key schedule.
// Expands the cipher key forward to round key 10, then streams round keys
// 10..0 over a valid/ready handshake. Each earlier key is regenerated from the
// current one with the inverse expansion step, so only one key is stored.
// One bank of four S-boxes serves both the forward and the inverse step.
module aes_dec_key_schedule (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] cipher_key,
  output logic         busy,
  output logic         key_valid,
  input  logic         key_ready,
  output logic [127:0] round_key,
  output logic [3:0]   round_idx,
  output logic         key_last
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXPAND,
    ST_EMIT
  } state_e;

  state_e       state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [3:0]   rc_q, rc_d;

  // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Forward S-box: multiplicative inverse (a^254, which maps 0 to 0)
  // followed by the AES affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] s;
    logic [7:0] r;
    s = a;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      s = gf_mul(s, s);
      r = gf_mul(r, s);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]}
             ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  // Round constant for rounds 1..10; other indices never reach the datapath.
  function automatic logic [7:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] p1, p2, p3;
  logic [31:0] sub_in, sub_rot, sub_out, t_word;
  logic [3:0]  rcon_idx;
  logic [127:0] fwd_key, inv_key;
  logic [31:0] f0, f1, f2, f3;

  assign w0 = key_q[127:96];
  assign w1 = key_q[95:64];
  assign w2 = key_q[63:32];
  assign w3 = key_q[31:0];

  // Previous-round words 1..3 fall out of plain XORs of the current key.
  assign p3 = w3 ^ w2;
  assign p2 = w2 ^ w1;
  assign p1 = w1 ^ w0;

  // Forward step substitutes w3; the inverse step substitutes the recovered
  // previous w3 (p3). Rcon is that of the round being produced (rc+1) going
  // forward, and that of the current round (rc) going backward.
  assign sub_in   = (state_q == ST_EMIT) ? p3 : w3;
  assign sub_rot  = {sub_in[23:0], sub_in[31:24]};
  assign rcon_idx = (state_q == ST_EMIT) ? rc_q : rc_q + 4'd1;

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    assign sub_out[8*g +: 8] = sbox(sub_rot[8*g +: 8]);
  end

  assign t_word = sub_out ^ {rcon(rcon_idx), 24'h000000};

  assign f0      = w0 ^ t_word;
  assign f1      = w1 ^ f0;
  assign f2      = w2 ^ f1;
  assign f3      = w3 ^ f2;
  assign fwd_key = {f0, f1, f2, f3};
  // In EMIT, w0 ^ t_word is exactly the previous round's w0.
  assign inv_key = {w0 ^ t_word, p1, p2, p3};

  // State, key and round counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q <= ST_IDLE;
      key_q   <= '0;
      rc_q    <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      rc_q    <= rc_d;
    end
  end

  // Next-state and next-key selection.
  always_comb begin
    // NOTE: hold values are assigned first so no path infers a latch.
    state_d = state_q;
    key_d   = key_q;
    rc_d    = rc_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          key_d   = cipher_key;
          rc_d    = 4'd0;
          state_d = ST_EXPAND;
        end
      end
      ST_EXPAND: begin
        key_d = fwd_key;
        rc_d  = rc_q + 4'd1;
        if (rc_q == 4'd9) state_d = ST_EMIT;
      end
      ST_EMIT: begin
        if (key_ready) begin
          if (rc_q != 4'd0) begin
            key_d = inv_key;
            rc_d  = rc_q - 4'd1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs depend only on registered state, never on key_ready.
  always_comb begin
    busy      = (state_q != ST_IDLE);
    key_valid = (state_q == ST_EMIT);
    key_last  = (state_q == ST_EMIT) && (rc_q == 4'd0);
    round_key = key_q;
    round_idx = rc_q;
  end

endmodule

// File: tb/tb_aes_dec_key_schedule.sv
// Testbench for aes_dec_key_schedule: known FIPS-197 vectors, backpressure,
// start-while-busy, mid-sequence reset, back-to-back and random keys, all
// compared against a textbook forward key expansion.
module tb_aes_dec_key_schedule;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] cipher_key;
  logic         busy;
  logic         key_valid;
  logic         key_ready;
  logic [127:0] round_key;
  logic [3:0]   round_idx;
  logic         key_last;

  always #5 clk = ~clk;

  aes_dec_key_schedule dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .cipher_key (cipher_key),
    .busy       (busy),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .round_key  (round_key),
    .round_idx  (round_idx),
    .key_last   (key_last)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]   sb     [256];
  logic [127:0] exp_rk [11];
  logic [127:0] cap_rk [11];

  typedef struct {
    logic [127:0] key;
    int           idx;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box table from a brute-force inverse search plus the bitwise affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] s;
    logic [7:0] c;
    c = 8'h63;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8]
               ^ inv[(i + 6) % 8] ^ inv[(i + 7) % 8] ^ c[i];
      sb[a] = s;
    end
  endtask

  // Textbook w[0..43] expansion; fills exp_rk[0..10].
  task automatic model_keys(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++)
      exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Pulse start at the current negedge; measure latency to the first key.
  // poke re-pulses start with another key during EXPAND.
  task automatic launch(input logic [127:0] k, input bit poke);
    int c;
    start      = 1'b1;
    cipher_key = k;
    @(negedge clk);
    start      = 1'b0;
    cipher_key = ~k;
    check("busy_on_start", busy, 1);
    c = 0;
    while (!key_valid && c < 40) begin
      if (poke && c == 4) begin
        start      = 1'b1;
        cipher_key = k ^ 128'h5a5a_5a5a_0000_ffff_1234_5678_9abc_def0;
      end
      @(negedge clk);
      start = 1'b0;
      c++;
    end
    check("latency", c, 10);
  endtask

  // Consume keys 10..0. mode 0: always ready, 1: 3-cycle stall at idx 7,
  // 2: random ready. abort_idx >= 0 resets mid-sequence at that index.
  // poke pulses start with another key while emitting idx 8.
  task automatic collect(input logic [127:0] k, input int mode, input int abort_idx, input bit poke);
    int idx;
    int guard;
    int stalls;
    bit r;
    model_keys(k);
    idx    = 10;
    guard  = 0;
    stalls = 0;
    while (idx >= 0 && guard < 200) begin
      check("key_valid", key_valid, 1);
      check("round_idx", round_idx, idx);
      check("round_key", round_key, exp_rk[idx]);
      check("key_last", key_last, idx == 0);
      if (abort_idx == idx) begin
        rst        = 1'b1;
        start      = 1'b1;
        cipher_key = ~k;
        key_ready  = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_valid", key_valid, 0);
        check("rst_last", key_last, 0);
        check("rst_round_key", round_key, 0);
        check("rst_round_idx", round_idx, 0);
        @(negedge clk);
        check("rst_idle_hold", busy, 0);
        return;
      end
      r = 1'b1;
      if (mode == 1 && idx == 7 && stalls < 3) begin
        r = 1'b0;
        stalls++;
      end
      if (mode == 2) r = ($urandom_range(0, 2) != 0);
      if (poke && idx == 8) begin
        start      = 1'b1;
        cipher_key = ~k;
      end
      key_ready = r;
      if (r) cap_rk[idx] = round_key;
      @(negedge clk);
      start = 1'b0;
      if (r) idx--;
      guard++;
    end
    check("seq_done", idx, -1);
    key_ready = 1'b1;
    check("busy_after", busy, 0);
    check("valid_after", key_valid, 0);
  endtask

  initial begin
    logic [127:0] k;
    build_sbox();
    vecs[0] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    vecs[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 1,  128'ha0fafe1788542cb123a339392a6c7605};
    vecs[2] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 0,  128'h2b7e151628aed2a6abf7158809cf4f3c};
    vecs[3] = '{128'h0,                                10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e};

    rst        = 1'b1;
    start      = 1'b0;
    key_ready  = 1'b1;
    cipher_key = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_valid", key_valid, 0);
    check("reset_last", key_last, 0);
    check("reset_round_key", round_key, 0);
    check("reset_round_idx", round_idx, 0);
    rst = 1'b0;
    @(negedge clk);

    // Known-answer vectors.
    for (int v = 0; v < 4; v++) begin
      launch(vecs[v].key, 1'b0);
      collect(vecs[v].key, 0, -1, 1'b0);
      check("known_vector", cap_rk[vecs[v].idx], vecs[v].exp);
    end

    // Backpressure: 3-cycle stall at round 7.
    launch(128'h000102030405060708090a0b0c0d0e0f, 1'b0);
    collect(128'h000102030405060708090a0b0c0d0e0f, 1, -1, 1'b0);

    // start while busy, in EXPAND and in EMIT.
    launch(128'h3c4fcf098815f7aba6d2ae2816157e2b, 1'b1);
    collect(128'h3c4fcf098815f7aba6d2ae2816157e2b, 0, -1, 1'b1);

    // Reset at round 5, then a clean full sequence.
    launch(128'hdeadbeef0123456789abcdeffeedface, 1'b0);
    collect(128'hdeadbeef0123456789abcdeffeedface, 0, 5, 1'b0);
    launch(128'hdeadbeef0123456789abcdeffeedface, 1'b0);
    collect(128'hdeadbeef0123456789abcdeffeedface, 0, -1, 1'b0);

    // All-FF key with random backpressure, then back-to-back start.
    launch({128{1'b1}}, 1'b0);
    collect({128{1'b1}}, 2, -1, 1'b0);
    launch(128'h0f0e0d0c0b0a09080706050403020100, 1'b0);
    collect(128'h0f0e0d0c0b0a09080706050403020100, 0, -1, 1'b0);

    // Random keys with random backpressure.
    for (int n = 0; n < 4; n++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      launch(k, 1'b0);
      collect(k, 2, -1, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
